// File: rtl/lab3_mem_line_unpacker_pkg.sv
// Shared types and constants for the lab3 memory line unpacker and the
// cache read path.
//   - Fixed geometry: a 128-bit line holds four 32-bit words, and a word
//     index within a line is 2 bits wide.
//   - Declares the unpacker FSM state type.
//   - Provides a helper that advances a word index with wrap 3 -> 0.
// No ports (package).
package lab3_mem_pkg;

  localparam int LINE_NBITS     = 128;
  localparam int WORD_NBITS     = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_IDX_NBITS = 2;

  typedef enum logic [0:0] {
    UNPK_IDLE = 1'b0,
    UNPK_SEND = 1'b1
  } unpk_state_t;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] line_t;
  typedef logic [1:0]   widx_t;

  // Next word index within a line.
  // The 2-bit arithmetic wraps from 3 back to 0, which gives the
  // critical-word-first ordering.
  function automatic widx_t widx_next(input widx_t idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/lab3_mem_line_unpacker_if.sv
// Stream bundle for the line unpacker. It carries two handshakes.
//
// Line request (producer -> unpacker):
//   in_val, in_rdy, in_line, in_offset
//
// Word response (unpacker -> consumer):
//   out_val, out_rdy, out_word, out_idx, out_last
//
// Modports:
//   master - environment side. It drives the line request and out_rdy.
//   slave  - unpacker side. It drives in_rdy and the word response.
interface lab3_mem_line_unpacker_if;
  import lab3_mem_pkg::*;

  logic  in_val;
  logic  in_rdy;
  line_t in_line;
  widx_t in_offset;
  logic  out_val;
  logic  out_rdy;
  word_t out_word;
  widx_t out_idx;
  logic  out_last;

  modport master (
    output in_val, in_line, in_offset, out_rdy,
    input  in_rdy, out_val, out_word, out_idx, out_last
  );

  modport slave (
    input  in_val, in_line, in_offset, out_rdy,
    output in_rdy, out_val, out_word, out_idx, out_last
  );

endinterface

// File: rtl/lab3_mem_line_unpacker_wordsel.sv
// lab3_mem_WordSel: purely combinational 4:1 word mux.
// Also used by the cache read path.
// Ports:
//   line - 128-bit cache line; word i occupies bits [32i+31:32i]
//   idx  - word index, 0..3
//   word - the selected 32-bit word
module lab3_mem_WordSel
  import lab3_mem_pkg::*;
(
  input  line_t line,
  input  widx_t idx,
  output word_t word
);

  // Select one word of the line by index.
  always_comb begin
    word = 32'd0;
    case (idx)
      2'd0:    word = line[31:0];
      2'd1:    word = line[63:32];
      2'd2:    word = line[95:64];
      2'd3:    word = line[127:96];
      default: word = 32'd0;
    endcase
  end

endmodule

// File: rtl/lab3_mem_line_unpacker.sv
// lab3_mem_line_unpacker: accepts one 128-bit line and emits its four
// 32-bit words serially. Emission starts at in_offset and wraps modulo 4
// (critical word first).
//
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - lab3_mem_line_unpacker_if.slave, carrying:
//               line request:  in_val / in_rdy / in_line / in_offset
//               word response: out_val / out_rdy / out_word / out_idx / out_last
//
// Compile-time option LAB3_MEM_LINE_UNPACKER_BACK2BACK_EN:
//   When defined, a new line may be accepted in the same cycle as the
//   final beat, so lines stream with no bubble.
//   When undefined, in_rdy is high only in IDLE, leaving one idle cycle
//   between lines.
//
// All word-side outputs come straight from flops, so there is no
// combinational path from in_* to out_*. Those outputs are loaded with the
// value of the beat that will be presented in the next cycle.
module lab3_mem_line_unpacker
  import lab3_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  lab3_mem_line_unpacker_if.slave   bus
);

  unpk_state_t state;
  unpk_state_t state_nxt;
  line_t       line_reg;
  line_t       line_nxt;
  widx_t       idx_reg;
  widx_t       idx_nxt;
  logic [1:0]  cnt_reg;
  logic [1:0]  cnt_nxt;

  // armed stays low until the first clock after reset release.
  // This keeps in_rdy low while reset is asserted, even though the state
  // register already reads IDLE.
  logic        armed;

  logic        in_rdy;
  logic        fire_in;
  logic        fire_out;

  logic        out_val_reg;
  word_t       out_word_reg;
  widx_t       out_idx_reg;
  logic        out_last_reg;

  logic        out_val_nxt;
  word_t       out_word_nxt;
  widx_t       out_idx_nxt;
  logic        out_last_nxt;
  word_t       sel_word;

  // Word that will be presented next cycle, taken from the next-state line and index.
  lab3_mem_WordSel u_wordsel (
    .line (line_nxt),
    .idx  (idx_nxt),
    .word (sel_word)
  );

`ifdef LAB3_MEM_LINE_UNPACKER_BACK2BACK_EN
  // Ready in IDLE, or on a final beat that is being consumed this cycle.
  assign in_rdy = (state == UNPK_IDLE) ? armed : (out_last_reg & bus.out_rdy);
`else
  // Ready only in IDLE.
  assign in_rdy = (state == UNPK_IDLE) ? armed : 1'b0;
`endif

  assign fire_in  = bus.in_val & in_rdy;
  assign fire_out = out_val_reg & bus.out_rdy;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= UNPK_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_nxt = state;
    line_nxt  = line_reg;
    idx_nxt   = idx_reg;
    cnt_nxt   = cnt_reg;
    case (state)
      UNPK_IDLE: begin
        if (fire_in) begin
          state_nxt = UNPK_SEND;
          line_nxt  = bus.in_line;
          idx_nxt   = bus.in_offset;
          cnt_nxt   = 2'd0;
        end else begin
          state_nxt = UNPK_IDLE;
        end
      end
      UNPK_SEND: begin
        if (fire_out && out_last_reg) begin
          if (fire_in) begin
            // Back-to-back: the next line replaces the one just finished.
            state_nxt = UNPK_SEND;
            line_nxt  = bus.in_line;
            idx_nxt   = bus.in_offset;
            cnt_nxt   = 2'd0;
          end else begin
            state_nxt = UNPK_IDLE;
            idx_nxt   = widx_next(idx_reg);
            cnt_nxt   = cnt_reg + 2'd1;
          end
        end else if (fire_out) begin
          state_nxt = UNPK_SEND;
          idx_nxt   = widx_next(idx_reg);
          cnt_nxt   = cnt_reg + 2'd1;
        end else begin
          state_nxt = UNPK_SEND;
        end
      end
      default: begin
        state_nxt = UNPK_IDLE;
      end
    endcase
  end

  // Next output values.
  // In IDLE, the word and index outputs hold their previous values.
  always_comb begin
    out_val_nxt  = 1'b0;
    out_word_nxt = out_word_reg;
    out_idx_nxt  = out_idx_reg;
    out_last_nxt = 1'b0;
    if (state_nxt == UNPK_SEND) begin
      out_val_nxt  = 1'b1;
      out_word_nxt = sel_word;
      out_idx_nxt  = idx_nxt;
      out_last_nxt = (cnt_nxt == 2'd3);
    end else begin
      out_val_nxt  = 1'b0;
      out_last_nxt = 1'b0;
    end
  end

  // Datapath registers: line, index, beat count, and ready arm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_reg <= 128'd0;
      idx_reg  <= 2'd0;
      cnt_reg  <= 2'd0;
      armed    <= 1'b0;
    end else begin
      line_reg <= line_nxt;
      idx_reg  <= idx_nxt;
      cnt_reg  <= cnt_nxt;
      armed    <= 1'b1;
    end
  end

  // Output registers.
  // Reset clears them immediately, so no partial line survives a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val_reg  <= 1'b0;
      out_word_reg <= 32'd0;
      out_idx_reg  <= 2'd0;
      out_last_reg <= 1'b0;
    end else begin
      out_val_reg  <= out_val_nxt;
      out_word_reg <= out_word_nxt;
      out_idx_reg  <= out_idx_nxt;
      out_last_reg <= out_last_nxt;
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_val  = out_val_reg;
  assign bus.out_word = out_word_reg;
  assign bus.out_idx  = out_idx_reg;
  assign bus.out_last = out_last_reg;

endmodule

// File: tb/tb_lab3_mem_line_unpacker.sv
// Directed testbench for lab3_mem_line_unpacker.
// Expected-value behaviour depends on LAB3_MEM_LINE_UNPACKER_BACK2BACK_EN.
module tb_lab3_mem_line_unpacker;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  lab3_mem_line_unpacker_if bus ();

  lab3_mem_line_unpacker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: abort the run if the directed sequence ever overruns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [31:0] w, input logic [1:0] i, input logic l);
    chk({tag, ".val"},  {31'd0, bus.out_val},  32'd1);
    chk({tag, ".word"}, bus.out_word,          w);
    chk({tag, ".idx"},  {30'd0, bus.out_idx},  {30'd0, i});
    chk({tag, ".last"}, {31'd0, bus.out_last}, {31'd0, l});
  endtask

  localparam logic [127:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_B = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_E = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;
  localparam logic [127:0] LINE_F = 128'h87654321_0FEDCBA9_13579BDF_2468ACE0;

  logic b2b;

  initial begin
    total = 0;
    bad   = 0;
`ifdef LAB3_MEM_LINE_UNPACKER_BACK2BACK_EN
    b2b = 1'b1;
`else
    b2b = 1'b0;
`endif
    reset_n       = 1'b0;
    bus.in_val    = 1'b0;
    bus.in_line   = 128'd0;
    bus.in_offset = 2'd0;
    bus.out_rdy   = 1'b0;
    step();
    step();

    // Reset state.
    chk("rst.out_val",  {31'd0, bus.out_val},  32'd0);
    chk("rst.in_rdy",   {31'd0, bus.in_rdy},   32'd0);
    chk("rst.out_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst.out_idx",  {30'd0, bus.out_idx},  32'd0);
    chk("rst.out_word", bus.out_word,          32'd0);
    reset_n = 1'b1;
    step();
    chk("idle.in_rdy",  {31'd0, bus.in_rdy},   32'd1);
    chk("idle.out_val", {31'd0, bus.out_val},  32'd0);

    // Test 1: offset 0, out_rdy held high.
    bus.in_val    = 1'b1;
    bus.in_line   = LINE_A;
    bus.in_offset = 2'd0;
    bus.out_rdy   = 1'b1;
    step();
    bus.in_val = 1'b0;
    beat("t1.b0", 32'hAAAAAAAA, 2'd0, 1'b0);
    chk("t1.b0.in_rdy", {31'd0, bus.in_rdy}, 32'd0);
    step(); beat("t1.b1", 32'hBBBBBBBB, 2'd1, 1'b0);
    step(); beat("t1.b2", 32'hCCCCCCCC, 2'd2, 1'b0);
    step(); beat("t1.b3", 32'hDDDDDDDD, 2'd3, 1'b1);
    chk("t1.b3.in_rdy", {31'd0, bus.in_rdy}, {31'd0, b2b});
    step();
    chk("t1.end.out_val",  {31'd0, bus.out_val},  32'd0);
    chk("t1.end.in_rdy",   {31'd0, bus.in_rdy},   32'd1);
    chk("t1.end.out_last", {31'd0, bus.out_last}, 32'd0);
    chk("t1.end.word_hold", bus.out_word,         32'hDDDDDDDD);
    chk("t1.end.idx_hold",  {30'd0, bus.out_idx}, 32'd3);

    // Test 2: offset 3, so the indices run 3,0,1,2.
    bus.in_val    = 1'b1;
    bus.in_offset = 2'd3;
    step();
    bus.in_val = 1'b0;
    beat("t2.b0", 32'hDDDDDDDD, 2'd3, 1'b0);
    step(); beat("t2.b1", 32'hAAAAAAAA, 2'd0, 1'b0);
    step(); beat("t2.b2", 32'hBBBBBBBB, 2'd1, 1'b0);
    step(); beat("t2.b3", 32'hCCCCCCCC, 2'd2, 1'b1);
    step();
    chk("t2.end.out_val", {31'd0, bus.out_val}, 32'd0);

    // Test 3: offset 1, with out_rdy toggled 1,0,0,1,1,0,1.
    // Ignored in_val pulses are issued while the line is being sent.
    bus.in_val    = 1'b1;
    bus.in_line   = LINE_B;
    bus.in_offset = 2'd1;
    step();
    bus.in_val = 1'b0;
    beat("t3.a", 32'h22222222, 2'd1, 1'b0);
    bus.out_rdy = 1'b1;
    step(); beat("t3.c0", 32'h33333333, 2'd2, 1'b0);
    bus.out_rdy   = 1'b0;
    bus.in_val    = 1'b1;
    bus.in_line   = LINE_E;
    bus.in_offset = 2'd0;
    chk("t3.c1.in_rdy", {31'd0, bus.in_rdy}, 32'd0);
    step(); beat("t3.c1", 32'h33333333, 2'd2, 1'b0);
    chk("t3.c2.in_rdy", {31'd0, bus.in_rdy}, 32'd0);
    step(); beat("t3.c2", 32'h33333333, 2'd2, 1'b0);
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b1;
    step(); beat("t3.c3", 32'h44444444, 2'd3, 1'b0);
    step(); beat("t3.c4", 32'h11111111, 2'd0, 1'b1);
    bus.out_rdy = 1'b0;
    chk("t3.c5.in_rdy", {31'd0, bus.in_rdy}, 32'd0);
    step(); beat("t3.c5", 32'h11111111, 2'd0, 1'b1);
    bus.out_rdy = 1'b1;
    step();
    chk("t3.end.out_val", {31'd0, bus.out_val}, 32'd0);
    chk("t3.end.in_rdy",  {31'd0, bus.in_rdy},  32'd1);

    // Test 4: two lines back to back.
    // LINE_A at offset 0, then LINE_B at offset 2.
    bus.in_val    = 1'b1;
    bus.in_line   = LINE_A;
    bus.in_offset = 2'd0;
    step();
    beat("t4.a0", 32'hAAAAAAAA, 2'd0, 1'b0);
    bus.in_line   = LINE_B;
    bus.in_offset = 2'd2;
    step(); beat("t4.a1", 32'hBBBBBBBB, 2'd1, 1'b0);
    step(); beat("t4.a2", 32'hCCCCCCCC, 2'd2, 1'b0);
    step(); beat("t4.a3", 32'hDDDDDDDD, 2'd3, 1'b1);
    step();
`ifndef LAB3_MEM_LINE_UNPACKER_BACK2BACK_EN
    chk("t4.gap.out_val", {31'd0, bus.out_val}, 32'd0);
    chk("t4.gap.in_rdy",  {31'd0, bus.in_rdy},  32'd1);
    step();
`endif
    bus.in_val = 1'b0;
    beat("t4.b0", 32'h33333333, 2'd2, 1'b0);
    step(); beat("t4.b1", 32'h44444444, 2'd3, 1'b0);
    step(); beat("t4.b2", 32'h11111111, 2'd0, 1'b0);
    step(); beat("t4.b3", 32'h22222222, 2'd1, 1'b1);
    step();
    chk("t4.end.out_val", {31'd0, bus.out_val}, 32'd0);

    // Test 5: asynchronous reset in the middle of a line.
    bus.in_val    = 1'b1;
    bus.in_line   = LINE_A;
    bus.in_offset = 2'd0;
    step();
    bus.in_val = 1'b0;
    step();
    step(); beat("t5.pre", 32'hCCCCCCCC, 2'd2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5.rst.out_val",  {31'd0, bus.out_val},  32'd0);
    chk("t5.rst.in_rdy",   {31'd0, bus.in_rdy},   32'd0);
    chk("t5.rst.out_last", {31'd0, bus.out_last}, 32'd0);
    chk("t5.rst.out_word", bus.out_word,          32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("t5.rel.in_rdy",   {31'd0, bus.in_rdy},  32'd1);
    chk("t5.rel.out_val",  {31'd0, bus.out_val}, 32'd0);
    chk("t5.rel.out_word", bus.out_word,         32'd0);
    step();
    chk("t5.idle2.out_val", {31'd0, bus.out_val}, 32'd0);
    bus.in_val    = 1'b1;
    bus.in_line   = LINE_F;
    bus.in_offset = 2'd2;
    step();
    bus.in_val = 1'b0;
    beat("t5.b0", 32'h0FEDCBA9, 2'd2, 1'b0);
    step(); beat("t5.b1", 32'h87654321, 2'd3, 1'b0);
    step(); beat("t5.b2", 32'h2468ACE0, 2'd0, 1'b0);
    step(); beat("t5.b3", 32'h13579BDF, 2'd1, 1'b1);
    step();
    chk("t5.end.out_val", {31'd0, bus.out_val}, 32'd0);
    chk("t5.end.in_rdy",  {31'd0, bus.in_rdy},  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
